// File: rtl/cpu_pkg.sv
// Shared types and encodings for the cpu_ctrl instruction sequencer.
package cpu_pkg;

  typedef enum logic [2:0] {
    WAIT, DECODE, GET_A, GET_B, EXEC, WR_IMM, WR_REG
  } state_t;

  localparam logic [2:0] OP_MOV = 3'b110;
  localparam logic [2:0] OP_ALU = 3'b101;

  localparam logic [1:0] MOV_IMM = 2'b10;
  localparam logic [1:0] MOV_REG = 2'b00;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_CMP = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

  typedef enum logic [2:0] {
    CL_MOV_IMM, CL_MOV_REG, CL_ALU, CL_CMP, CL_MVN, CL_UNDEF
  } iclass_t;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [1:0]  op;
    logic [2:0]  rn;
    logic [2:0]  rd;
    logic [2:0]  rm;
    logic [1:0]  shift;
    logic [1:0]  aluOp;
    logic [15:0] sximm8;
  } instr_t;

  // ADD and AND share the read-A / read-B / execute / write-back path.
  function automatic iclass_t classify(input logic [2:0] opcode, input logic [1:0] op);
    iclass_t cl;
    cl = CL_UNDEF;
    if (opcode == OP_MOV) begin
      if (op == MOV_IMM)      cl = CL_MOV_IMM;
      else if (op == MOV_REG) cl = CL_MOV_REG;
    end else if (opcode == OP_ALU) begin
      case (op)
        ALU_ADD, ALU_AND: cl = CL_ALU;
        ALU_CMP:          cl = CL_CMP;
        default:          cl = CL_MVN;
      endcase
    end
    return cl;
  endfunction

endpackage

// File: rtl/cpu_ctrl_if.sv
// Control bus between the sequencer and the instruction source / regfile / datapath.
interface cpu_ctrl_if;
  logic        s;
  logic [15:0] in;
  logic        w;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write;
  logic        vsel;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        asel;
  logic        bsel;
  logic [1:0]  ALUop;
  logic [1:0]  shift;
  logic [15:0] sximm8;

  modport master (
    input  s, in,
    output w, readnum, writenum, write, vsel, loada, loadb, loadc, loads,
           asel, bsel, ALUop, shift, sximm8
  );

  modport slave (
    output s, in,
    input  w, readnum, writenum, write, vsel, loada, loadb, loadc, loads,
           asel, bsel, ALUop, shift, sximm8
  );
endinterface

// File: rtl/instr_dec.sv
// Splits the latched instruction word into its fields.
module instr_dec
  import cpu_pkg::*;
(
  input  logic [15:0] ir_i,
  output instr_t      dec_o
);

  always_comb begin
    dec_o.opcode = ir_i[15:13];
    dec_o.op     = ir_i[12:11];
    dec_o.rn     = ir_i[10:8];
    dec_o.rd     = ir_i[7:5];
    dec_o.rm     = ir_i[2:0];
    dec_o.shift  = ir_i[4:3];
    dec_o.aluOp  = ir_i[12:11];
    dec_o.sximm8 = {{8{ir_i[7]}}, ir_i[7:0]};
  end

endmodule

// File: rtl/cpu_ctrl.sv
// Instruction sequencer: latches one instruction and steps the regfile/datapath
// controls through a Moore FSM.
module cpu_ctrl
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  cpu_ctrl_if.master bus
);

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  instr_t      dec;
  iclass_t     iclass;

  logic       w_q, write_q, vsel_q, asel_q;
  logic       loada_q, loadb_q, loadc_q, loads_q;
  logic [2:0] readnum_q, writenum_q;

  instr_dec u_dec (
    .ir_i  (ir_q),
    .dec_o (dec)
  );

  assign iclass = classify(dec.opcode, dec.op);

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      WAIT: begin
        if (bus.s) begin
          ir_d    = bus.in;
          state_d = DECODE;
        end
      end
      DECODE: begin
        case (iclass)
          CL_MOV_IMM:         state_d = WR_IMM;
          CL_ALU, CL_CMP:     state_d = GET_A;
          CL_MOV_REG, CL_MVN: state_d = GET_B;
          default:            state_d = WAIT;
        endcase
      end
      GET_A:          state_d = GET_B;
      GET_B:          state_d = EXEC;
      EXEC:           state_d = (iclass == CL_CMP) ? WAIT : WR_REG;
      WR_IMM, WR_REG: state_d = WAIT;
      default:        state_d = WAIT;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q;
  // IR only changes on entry to DECODE, so dec is already valid for them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= WAIT;
      ir_q       <= '0;
      w_q        <= 1'b1;
      write_q    <= 1'b0;
      vsel_q     <= 1'b0;
      asel_q     <= 1'b0;
      loada_q    <= 1'b0;
      loadb_q    <= 1'b0;
      loadc_q    <= 1'b0;
      loads_q    <= 1'b0;
      readnum_q  <= '0;
      writenum_q <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      w_q     <= (state_d == WAIT);
      loada_q <= (state_d == GET_A);
      loadb_q <= (state_d == GET_B);
      loadc_q <= (state_d == EXEC) && (iclass != CL_CMP);
      loads_q <= (state_d == EXEC) && (iclass == CL_CMP);
      asel_q  <= (state_d == EXEC) && ((iclass == CL_MOV_REG) || (iclass == CL_MVN));
      write_q <= (state_d == WR_IMM) || (state_d == WR_REG);
      vsel_q  <= (state_d == WR_IMM);
      if (state_d == GET_A)      readnum_q <= dec.rn;
      else if (state_d == GET_B) readnum_q <= dec.rm;
      if (state_d == WR_IMM)      writenum_q <= dec.rn;
      else if (state_d == WR_REG) writenum_q <= dec.rd;
    end
  end

  assign bus.w        = w_q;
  assign bus.readnum  = readnum_q;
  assign bus.writenum = writenum_q;
  assign bus.write    = write_q;
  assign bus.vsel     = vsel_q;
  assign bus.loada    = loada_q;
  assign bus.loadb    = loadb_q;
  assign bus.loadc    = loadc_q;
  assign bus.loads    = loads_q;
  assign bus.asel     = asel_q;
  assign bus.bsel     = 1'b0;
  assign bus.ALUop    = dec.aluOp;
  assign bus.shift    = dec.shift;
  assign bus.sximm8   = dec.sximm8;

endmodule

// File: tb/tb_cpu_ctrl.sv
// Bench for cpu_ctrl with a behavioural regfile/datapath and an ISA-level scoreboard.
module tb_cpu_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  cpu_ctrl_if bus ();

  cpu_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  int total = 0;
  int passed = 0;

  typedef struct {
    logic [2:0]  rd;
    logic [15:0] val;
  } exp_t;

  exp_t        sbQ[$];
  exp_t        sbE;
  logic [15:0] refR [8] = '{default: 16'h0};
  logic [15:0] rf   [8] = '{default: 16'h0};
  logic [15:0] regA, regB, regC, shOut, aluA, aluOut, dataIn;
  logic        zFlag;

  // Datapath and regfile driven by the sequencer's controls
  always_comb begin
    case (bus.shift)
      2'b00:   shOut = regB;
      2'b01:   shOut = {regB[14:0], 1'b0};
      2'b10:   shOut = {1'b0, regB[15:1]};
      default: shOut = {regB[15], regB[15:1]};
    endcase
    aluA = bus.asel ? 16'h0 : regA;
    case (bus.ALUop)
      2'b00:   aluOut = aluA + shOut;
      2'b01:   aluOut = aluA - shOut;
      2'b10:   aluOut = aluA & shOut;
      default: aluOut = ~shOut;
    endcase
    dataIn = bus.vsel ? bus.sximm8 : regC;
  end

  always @(posedge clk) begin
    if (bus.loada) regA <= rf[bus.readnum];
    if (bus.loadb) regB <= rf[bus.readnum];
    if (bus.loadc) regC <= aluOut;
    if (bus.loads) zFlag <= (aluOut == 16'h0);
    if (bus.write) rf[bus.writenum] <= dataIn;
  end

  // Scoreboard on every write, plus the one-enable-at-a-time rule
  always @(negedge clk) begin
    if (reset_n === 1'b1 && bus.write === 1'b1) begin
      total++;
      if (sbQ.size() == 0) begin
        $display("[TB] FAIL sb_unexpected_write: writenum=%0d data=%h, required no write", bus.writenum, dataIn);
      end else begin
        sbE = sbQ.pop_front();
        if (bus.writenum !== sbE.rd || dataIn !== sbE.val)
          $display("[TB] FAIL sb_write: got R%0d=%h, expected R%0d=%h", bus.writenum, dataIn, sbE.rd, sbE.val);
        else passed++;
      end
    end
    if (reset_n === 1'b1) begin
      total++;
      if ($countones({bus.loada, bus.loadb, bus.loadc, bus.loads, bus.write}) > 1)
        $display("[TB] FAIL onehot_enables: {la,lb,lc,ls,wr}=%b, expected at most one set",
                 {bus.loada, bus.loadb, bus.loadc, bus.loads, bus.write});
      else passed++;
    end
  end

  function automatic logic [15:0] shiftModel(input logic [15:0] v, input logic [1:0] sh);
    case (sh)
      2'b00:   return v;
      2'b01:   return v << 1;
      2'b10:   return v >> 1;
      default: return {v[15], v[15:1]};
    endcase
  endfunction

  // ISA-level reference: pushes the expected register write, if any
  function automatic void pushExpected(input logic [15:0] ir);
    logic [2:0]  opc, rn, rd, rm;
    logic [1:0]  op;
    logic [15:0] b;
    exp_t        e;
    logic        valid;
    opc = ir[15:13]; op = ir[12:11];
    rn  = ir[10:8];  rd = ir[7:5];  rm = ir[2:0];
    b   = shiftModel(refR[rm], ir[4:3]);
    valid = 1'b1;
    e.rd = rd;
    e.val = 16'h0;
    if (opc == 3'b110 && op == 2'b10) begin
      e.rd = rn; e.val = {{8{ir[7]}}, ir[7:0]};
    end else if (opc == 3'b110 && op == 2'b00) e.val = b;
    else if (opc == 3'b101 && op == 2'b00)    e.val = refR[rn] + b;
    else if (opc == 3'b101 && op == 2'b10)    e.val = refR[rn] & b;
    else if (opc == 3'b101 && op == 2'b11)    e.val = ~b;
    else valid = 1'b0;
    if (valid) begin
      sbQ.push_back(e);
      refR[e.rd] = e.val;
    end
  endfunction

  // Waits (bounded) for ready, then presents one instruction for a single cycle
  task automatic applyStimulus(input logic [15:0] instr);
    int n;
    n = 0;
    while (bus.w !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (bus.w !== 1'b1) $display("[TB] FAIL ready_timeout: w=%b after %0d cycles, expected 1", bus.w, n);
    else passed++;
    pushExpected(instr);
    bus.s  = 1'b1;
    bus.in = instr;
    @(negedge clk);
    bus.s = 1'b0;
  endtask

  task automatic test_reset();
    bus.s = 1'b1; bus.in = 16'hD7FF; reset_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.w, bus.readnum, bus.writenum, bus.write, bus.vsel, bus.loada, bus.loadb, bus.loadc,
         bus.loads, bus.asel, bus.bsel, bus.ALUop, bus.shift, bus.sximm8} !== {1'b1, 34'b0})
      $display("[TB] FAIL reset_outputs: w=%b rn=%0d wn=%0d wr=%b sx=%h, expected w=1 others 0",
               bus.w, bus.readnum, bus.writenum, bus.write, bus.sximm8);
    else passed++;
    bus.s = 1'b0; bus.in = 16'h0;
    reset_n = 1'b1;
    @(negedge clk);
    total++;
    if (bus.w !== 1'b1) $display("[TB] FAIL reset_idle: w=%b, expected 1", bus.w); else passed++;
  endtask

  task automatic test_mov_imm();
    applyStimulus(16'hD32A);
    total++;
    if (bus.w !== 1'b0 || bus.write !== 1'b0) $display("[TB] FAIL movimm_decode: w=%b write=%b, expected 0 0", bus.w, bus.write); else passed++;
    @(negedge clk);
    total++;
    if (bus.write !== 1'b1 || bus.writenum !== 3'd3 || bus.vsel !== 1'b1)
      $display("[TB] FAIL movimm_wr: write=%b writenum=%0d vsel=%b, expected 1 3 1", bus.write, bus.writenum, bus.vsel);
    else passed++;
    total++;
    if (bus.sximm8 !== 16'h002A) $display("[TB] FAIL movimm_sximm8: %h, expected 002a", bus.sximm8); else passed++;
    @(negedge clk);
    total++;
    if (bus.w !== 1'b1 || rf[3] !== 16'd42) $display("[TB] FAIL movimm_done: w=%b R3=%0d, expected 1 42", bus.w, rf[3]); else passed++;
    applyStimulus(16'hD00C);
    applyStimulus(16'hD116);
  endtask

  task automatic test_add();
    applyStimulus(16'hA140);
    @(negedge clk);
    total++;
    if (bus.readnum !== 3'd1 || bus.loada !== 1'b1) $display("[TB] FAIL add_get_a: readnum=%0d loada=%b, expected 1 1", bus.readnum, bus.loada); else passed++;
    @(negedge clk);
    total++;
    if (bus.readnum !== 3'd0 || bus.loadb !== 1'b1) $display("[TB] FAIL add_get_b: readnum=%0d loadb=%b, expected 0 1", bus.readnum, bus.loadb); else passed++;
    @(negedge clk);
    total++;
    if (bus.loadc !== 1'b1 || bus.asel !== 1'b0) $display("[TB] FAIL add_exec: loadc=%b asel=%b, expected 1 0", bus.loadc, bus.asel); else passed++;
    @(negedge clk);
    total++;
    if (bus.write !== 1'b1 || bus.writenum !== 3'd2 || bus.vsel !== 1'b0)
      $display("[TB] FAIL add_wr: write=%b writenum=%0d vsel=%b, expected 1 2 0", bus.write, bus.writenum, bus.vsel);
    else passed++;
    @(negedge clk);
    total++;
    if (bus.w !== 1'b1 || rf[2] !== 16'd34) $display("[TB] FAIL add_done: w=%b R2=%0d, expected 1 34", bus.w, rf[2]); else passed++;
  endtask

  task automatic test_cmp();
    int nLoads, nWrites;
    nLoads = 0; nWrites = 0;
    applyStimulus(16'hA900);
    for (int i = 0; i < 4; i++) begin
      nLoads += int'(bus.loads);
      nWrites += int'(bus.write);
      @(negedge clk);
    end
    total++;
    if (nLoads != 1 || nWrites != 0 || bus.w !== 1'b1)
      $display("[TB] FAIL cmp_seq: loads=%0d writes=%0d w=%b, expected 1 0 1", nLoads, nWrites, bus.w);
    else passed++;
    total++;
    if (zFlag !== 1'b0) $display("[TB] FAIL cmp_ne_z: Z=%b, expected 0", zFlag); else passed++;
    applyStimulus(16'hA901);
    repeat (4) @(negedge clk);
    total++;
    if (zFlag !== 1'b1) $display("[TB] FAIL cmp_eq_z: Z=%b, expected 1", zFlag); else passed++;
  endtask

  task automatic test_mvn_movreg();
    applyStimulus(16'hB888);
    total++;
    if (bus.shift !== 2'b01 || bus.ALUop !== 2'b11) $display("[TB] FAIL mvn_fields: shift=%b ALUop=%b, expected 01 11", bus.shift, bus.ALUop); else passed++;
    @(negedge clk);
    total++;
    if (bus.readnum !== 3'd0 || bus.loadb !== 1'b1 || bus.loada !== 1'b0)
      $display("[TB] FAIL mvn_get_b: readnum=%0d loadb=%b loada=%b, expected 0 1 0", bus.readnum, bus.loadb, bus.loada);
    else passed++;
    @(negedge clk);
    total++;
    if (bus.asel !== 1'b1 || bus.loadc !== 1'b1) $display("[TB] FAIL mvn_exec: asel=%b loadc=%b, expected 1 1", bus.asel, bus.loadc); else passed++;
    @(negedge clk);
    total++;
    if (bus.write !== 1'b1 || bus.writenum !== 3'd4) $display("[TB] FAIL mvn_wr: write=%b writenum=%0d, expected 1 4", bus.write, bus.writenum); else passed++;
    @(negedge clk);
    total++;
    if (bus.w !== 1'b1 || rf[4] !== 16'hFFE7) $display("[TB] FAIL mvn_done: w=%b R4=%h, expected 1 ffe7", bus.w, rf[4]); else passed++;
    applyStimulus(16'hC0A3);
    @(negedge clk);
    total++;
    if (bus.readnum !== 3'd3 || bus.loadb !== 1'b1) $display("[TB] FAIL movreg_get_b: readnum=%0d loadb=%b, expected 3 1", bus.readnum, bus.loadb); else passed++;
    @(negedge clk);
    total++;
    if (bus.asel !== 1'b1) $display("[TB] FAIL movreg_exec: asel=%b, expected 1", bus.asel); else passed++;
    @(negedge clk);
    total++;
    if (bus.write !== 1'b1 || bus.writenum !== 3'd5) $display("[TB] FAIL movreg_wr: write=%b writenum=%0d, expected 1 5", bus.write, bus.writenum); else passed++;
    @(negedge clk);
    total++;
    if (rf[5] !== 16'd42) $display("[TB] FAIL movreg_done: R5=%0d, expected 42", rf[5]); else passed++;
  endtask

  task automatic test_undefined();
    applyStimulus(16'hE000);
    total++;
    if (bus.w !== 1'b0 || {bus.loada, bus.loadb, bus.loadc, bus.loads, bus.write} !== 5'b0)
      $display("[TB] FAIL undef_decode: w=%b en=%b, expected 0 00000", bus.w, {bus.loada, bus.loadb, bus.loadc, bus.loads, bus.write});
    else passed++;
    @(negedge clk);
    total++;
    if (bus.w !== 1'b1 || {bus.loada, bus.loadb, bus.loadc, bus.loads, bus.write} !== 5'b0)
      $display("[TB] FAIL undef_wait: w=%b en=%b, expected 1 00000", bus.w, {bus.loada, bus.loadb, bus.loadc, bus.loads, bus.write});
    else passed++;
  endtask

  task automatic test_busy_ignore();
    applyStimulus(16'hB1C0);
    for (int i = 0; i < 3; i++) begin
      bus.s  = (i != 1);
      bus.in = 16'(($urandom & 32'h1FFF) | 32'hC000);
      @(negedge clk);
    end
    bus.s = 1'b0;
    total++;
    if (bus.loadc !== 1'b1 || bus.ALUop !== 2'b10) $display("[TB] FAIL busy_exec: loadc=%b ALUop=%b, expected 1 10", bus.loadc, bus.ALUop); else passed++;
    @(negedge clk);
    total++;
    if (bus.write !== 1'b1 || bus.writenum !== 3'd6) $display("[TB] FAIL busy_wr: write=%b writenum=%0d, expected 1 6", bus.write, bus.writenum); else passed++;
    @(negedge clk);
    total++;
    if (bus.w !== 1'b1 || rf[6] !== 16'd4) $display("[TB] FAIL busy_done: w=%b R6=%0d, expected 1 4", bus.w, rf[6]); else passed++;
  endtask

  task automatic test_back_to_back();
    pushExpected(16'hD705);
    bus.s = 1'b1; bus.in = 16'hD705;
    @(negedge clk);
    total++;
    if (bus.w !== 1'b0) $display("[TB] FAIL b2b_first_accept: w=%b, expected 0", bus.w); else passed++;
    pushExpected(16'hD7FD);
    bus.in = 16'hD7FD;
    @(negedge clk);
    total++;
    if (bus.write !== 1'b1 || bus.sximm8 !== 16'h0005) $display("[TB] FAIL b2b_first_wr: write=%b sximm8=%h, expected 1 0005", bus.write, bus.sximm8); else passed++;
    @(negedge clk);
    total++;
    if (bus.w !== 1'b1 || rf[7] !== 16'd5) $display("[TB] FAIL b2b_first_done: w=%b R7=%h, expected 1 0005", bus.w, rf[7]); else passed++;
    @(negedge clk);
    total++;
    if (bus.w !== 1'b0) $display("[TB] FAIL b2b_second_accept: w=%b, expected 0", bus.w); else passed++;
    bus.s = 1'b0;
    @(negedge clk);
    total++;
    if (bus.write !== 1'b1 || bus.sximm8 !== 16'hFFFD) $display("[TB] FAIL b2b_second_wr: write=%b sximm8=%h, expected 1 fffd", bus.write, bus.sximm8); else passed++;
    @(negedge clk);
    total++;
    if (bus.w !== 1'b1 || rf[7] !== 16'hFFFD) $display("[TB] FAIL b2b_second_done: w=%b R7=%h, expected 1 fffd", bus.w, rf[7]); else passed++;
  endtask

  task automatic test_reset_mid_write();
    applyStimulus(16'hA1C0);
    refR[6] = 16'd4;
    repeat (4) @(negedge clk);
    total++;
    if (bus.write !== 1'b1 || bus.writenum !== 3'd6) $display("[TB] FAIL rst_pre_wr: write=%b writenum=%0d, expected 1 6", bus.write, bus.writenum); else passed++;
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (bus.write !== 1'b0 || bus.w !== 1'b1 || bus.ALUop !== 2'b00)
      $display("[TB] FAIL rst_async: write=%b w=%b ALUop=%b, expected 0 1 00", bus.write, bus.w, bus.ALUop);
    else passed++;
    @(negedge clk);
    reset_n = 1'b1;
    total++;
    if (rf[6] !== 16'd4) $display("[TB] FAIL rst_dropped_write: R6=%0d, expected 4", rf[6]); else passed++;
    @(negedge clk);
    total++;
    if (bus.w !== 1'b1) $display("[TB] FAIL rst_idle: w=%b, expected 1", bus.w); else passed++;
  endtask

  task automatic test_final_regs();
    for (int i = 0; i < 8; i++) begin
      total++;
      if (rf[i] !== refR[i]) $display("[TB] FAIL final_R%0d: %h, expected %h", i, rf[i], refR[i]); else passed++;
    end
    total++;
    if (sbQ.size() != 0) $display("[TB] FAIL sb_leftover: %0d writes never seen, expected 0", sbQ.size()); else passed++;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] cpu_ctrl bench starting");
    test_reset();
    test_mov_imm();
    test_add();
    test_cmp();
    test_mvn_movreg();
    test_undefined();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_write();
    test_final_regs();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
